// File: rtl/dith_round_robin_if.sv
// Handshake bundle for the dither round-robin sequencer.
// master = controller side driving enables/triggers, slave = sequencer.
interface dith_round_robin_if #(
   parameter int N_CH = 2,
   parameter int CW   = 32
);
   localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                 EN;
   logic [N_CH-1:0]      trig;
   logic [N_CH*CW-1:0]   cnt_MAX;
   logic [N_CH-1:0]      chMask;
   logic [N_CH-1:0]      dithEN;
   logic [AW-1:0]        active_ch;
   logic                 ho_pulse;
   logic                 ho_timeout;

   modport master (
      output EN, trig, cnt_MAX, chMask,
      input  dithEN, active_ch, ho_pulse, ho_timeout
   );

   modport slave (
      input  EN, trig, cnt_MAX, chMask,
      output dithEN, active_ch, ho_pulse, ho_timeout
   );
endinterface

// File: rtl/dith_round_robin.sv
// Round-robin dither sequencer: one channel dithers for cnt_MAX+1 modulation cycles,
// then a one-cycle gap and a handoff that waits for the outgoing channel's cycle end.
module dith_round_robin #(
   parameter int N_CH       = 2,
   parameter int CW         = 32,
   parameter int START_CH   = 1,
   parameter int HO_TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               rst,
   dith_round_robin_if.slave  bus
);
   localparam int AW     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int TW     = (HO_TIMEOUT > 1) ? $clog2(HO_TIMEOUT + 1) : 1;
   localparam int TO_LIM = (HO_TIMEOUT > 0) ? HO_TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] CNT_SAT   = '1;
   localparam logic [AW-1:0] START_IDX = AW'(START_CH);

   typedef enum logic [1:0] {IDLE, RUN, GAP, HANDOFF} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt, cnt_inc, cmax;
   logic [AW-1:0]   act, act_nxt, prev, prev_nxt, start_ch;
   logic [N_CH-1:0] dith, dith_nxt;
   logic            hop, hop_nxt, hot, hot_nxt;
   logic [TW-1:0]   hoc, hoc_nxt, hoc_inc;
   logic            timed_out;

   // First unmasked channel after c, wrapping; c itself is considered last.
   function automatic logic [AW-1:0] next_ch(input logic [AW-1:0] c, input logic [N_CH-1:0] m);
      logic [AW-1:0] r;
      logic          found;
      int            idx;
      r     = c;
      found = 1'b0;
      for (int i = 1; i <= N_CH; i++) begin
         idx = (int'(c) + i) % N_CH;
         if (!found && m[idx]) begin
            r     = AW'(idx);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [N_CH-1:0] onehot(input logic [AW-1:0] c);
      return N_CH'(1) << c;
   endfunction

   assign start_ch  = bus.chMask[START_IDX] ? START_IDX : next_ch(START_IDX, bus.chMask);
   assign cmax      = bus.cnt_MAX[int'(act)*CW +: CW];
   assign cnt_inc   = (bus.trig[act] && (cnt != CNT_SAT)) ? cnt + 1'b1 : cnt;
   assign hoc_inc   = (hoc == '1) ? hoc : hoc + 1'b1;
   assign timed_out = (HO_TIMEOUT > 0) && (hoc >= TW'(TO_LIM));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         act   <= '0;
         prev  <= '0;
         dith  <= '0;
         hop   <= 1'b0;
         hot   <= 1'b0;
         hoc   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         act   <= act_nxt;
         prev  <= prev_nxt;
         dith  <= dith_nxt;
         hop   <= hop_nxt;
         hot   <= hot_nxt;
         hoc   <= hoc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      act_nxt   = act;
      prev_nxt  = prev;
      dith_nxt  = dith;
      hop_nxt   = 1'b0;
      hot_nxt   = 1'b0;
      hoc_nxt   = hoc;

      if (!bus.EN || (bus.chMask == '0)) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         act_nxt   = '0;
         dith_nxt  = '0;
         hoc_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = RUN;
               act_nxt   = start_ch;
               dith_nxt  = onehot(start_ch);
               hop_nxt   = 1'b1;
               cnt_nxt   = '0;
            end
            RUN: begin
               if (!bus.chMask[act] || (cnt_inc > cmax)) begin
                  state_nxt = GAP;
                  dith_nxt  = '0;
                  cnt_nxt   = '0;
                  prev_nxt  = act;
                  act_nxt   = next_ch(act, bus.chMask);
                  hoc_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            GAP: begin
               state_nxt = HANDOFF;
               if (!bus.chMask[act]) act_nxt = next_ch(prev, bus.chMask);
            end
            HANDOFF: begin
               // A masked target is re-chosen first; the handoff still waits on prev.
               if (!bus.chMask[act]) begin
                  act_nxt = next_ch(prev, bus.chMask);
                  hoc_nxt = hoc_inc;
               end else if (bus.trig[prev] || timed_out) begin
                  state_nxt = RUN;
                  dith_nxt  = onehot(act);
                  hop_nxt   = 1'b1;
                  hot_nxt   = !bus.trig[prev];
                  cnt_nxt   = '0;
               end else begin
                  hoc_nxt = hoc_inc;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.dithEN     = dith;
   assign bus.active_ch  = act;
   assign bus.ho_pulse   = hop;
   assign bus.ho_timeout = hot;
endmodule

// File: tb/tb_dith_round_robin.sv
// Directed bench: per-cycle vector table on a 2-channel instance, plus hand sequences
// for saturation, 4-channel rotation order and handoff timeout.
module tb_dith_round_robin;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dith_round_robin_if #(.N_CH(2), .CW(4)) a ();
   dith_round_robin_if #(.N_CH(4), .CW(4)) b ();

   dith_round_robin #(.N_CH(2), .CW(4), .START_CH(1), .HO_TIMEOUT(0))  dut_a (.clk(clk), .rst(rst), .bus(a));
   dith_round_robin #(.N_CH(4), .CW(4), .START_CH(2), .HO_TIMEOUT(50)) dut_b (.clk(clk), .rst(rst), .bus(b));

   typedef struct {
      logic       r;
      logic       en;
      logic [1:0] trig;
      logic [1:0] mask;
      logic [1:0] dith;
      logic       act;
      logic       hop;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic en, input logic [1:0] t, input logic [1:0] m,
                      input logic [1:0] d, input logic ac, input logic hp);
      vec_t v;
      v.r = r; v.en = en; v.trig = t; v.mask = m; v.dith = d; v.act = ac; v.hop = hp;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("onehot_a", 32'($countones(a.dithEN) <= 1), 32'd1);
         chk("onehot_b", 32'($countones(b.dithEN) <= 1), 32'd1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int        n;
      int        cur;
      int        nx;
      int        order [5];
      logic [3:0] oh;

      a.EN = 1'b0; a.trig = '0; a.chMask = 2'b11; a.cnt_MAX = {4'd2, 4'd3};
      b.EN = 1'b0; b.trig = '0; b.chMask = 4'b1011; b.cnt_MAX = '0;

      //   rst en  trig   mask   dith  act hop
      add(1, 0, 2'b00, 2'b11, 2'b00, 0, 0);
      add(0, 0, 2'b00, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b11, 2'b10, 1, 1);
      add(0, 1, 2'b00, 2'b11, 2'b10, 1, 0);
      add(0, 1, 2'b01, 2'b11, 2'b10, 1, 0);
      add(0, 1, 2'b10, 2'b11, 2'b10, 1, 0);
      add(0, 1, 2'b10, 2'b11, 2'b10, 1, 0);
      add(0, 1, 2'b10, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b10, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b01, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b10, 2'b11, 2'b01, 0, 1);
      add(0, 1, 2'b01, 2'b11, 2'b01, 0, 0);
      add(0, 1, 2'b01, 2'b11, 2'b01, 0, 0);
      add(0, 1, 2'b01, 2'b11, 2'b01, 0, 0);
      add(0, 1, 2'b01, 2'b11, 2'b00, 1, 0);
      add(0, 1, 2'b00, 2'b11, 2'b00, 1, 0);
      add(0, 1, 2'b01, 2'b11, 2'b10, 1, 1);
      add(0, 1, 2'b10, 2'b11, 2'b10, 1, 0);
      add(0, 1, 2'b10, 2'b11, 2'b10, 1, 0);
      add(0, 0, 2'b00, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b11, 2'b10, 1, 1);
      add(0, 1, 2'b10, 2'b11, 2'b10, 1, 0);
      add(0, 1, 2'b10, 2'b11, 2'b10, 1, 0);
      add(0, 1, 2'b10, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b01, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b10, 2'b00, 1, 0);
      add(0, 1, 2'b10, 2'b10, 2'b10, 1, 1);
      add(0, 1, 2'b00, 2'b01, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b01, 2'b00, 0, 0);
      add(0, 1, 2'b10, 2'b01, 2'b01, 0, 1);
      add(0, 1, 2'b01, 2'b01, 2'b01, 0, 0);
      add(0, 1, 2'b01, 2'b01, 2'b01, 0, 0);
      add(0, 1, 2'b01, 2'b01, 2'b01, 0, 0);
      add(0, 1, 2'b01, 2'b01, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b01, 2'b00, 0, 0);
      add(0, 1, 2'b01, 2'b01, 2'b01, 0, 1);
      add(0, 1, 2'b00, 2'b00, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b00, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b11, 2'b10, 1, 1);
      add(0, 1, 2'b10, 2'b11, 2'b10, 1, 0);
      add(0, 1, 2'b10, 2'b11, 2'b10, 1, 0);
      add(0, 1, 2'b10, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b11, 2'b00, 0, 0);
      add(1, 1, 2'b10, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b11, 2'b10, 1, 1);
      add(1, 1, 2'b10, 2'b11, 2'b00, 0, 0);
      add(0, 0, 2'b00, 2'b11, 2'b00, 0, 0);
      add(0, 1, 2'b00, 2'b01, 2'b01, 0, 1);

      foreach (tbl[i]) begin
         rst = tbl[i].r; a.EN = tbl[i].en; a.trig = tbl[i].trig; a.chMask = tbl[i].mask;
         tick;
         chk($sformatf("row%0d_dith", i), 32'(a.dithEN), 32'(tbl[i].dith));
         chk($sformatf("row%0d_act", i), 32'(a.active_ch), 32'(tbl[i].act));
         chk($sformatf("row%0d_hop", i), 32'(a.ho_pulse), 32'(tbl[i].hop));
         chk($sformatf("row%0d_hot", i), 32'(a.ho_timeout), 32'd0);
      end

      // Saturating counter: cnt_MAX at all-ones never ends the run; lowering it ends it live.
      rst = 1'b1; a.EN = 1'b0; a.trig = '0; tick;
      rst = 1'b0; a.cnt_MAX = {4'd2, 4'd15}; a.chMask = 2'b01; a.EN = 1'b1; tick;
      chk("sat_start", 32'(a.dithEN), 32'h1);
      for (int k = 0; k < 20; k++) begin
         a.trig = 2'b01; tick; a.trig = '0; tick;
         chk($sformatf("sat_run%0d", k), 32'(a.dithEN), 32'h1);
      end
      a.cnt_MAX = {4'd2, 4'd1}; tick;
      chk("sat_live_gap", 32'(a.dithEN), 32'h0);
      chk("sat_live_act", 32'(a.active_ch), 32'h0);
      a.EN = 1'b0; tick;

      // Four-channel rotation with START_CH masked: order 3,0,1,3,0.
      order = '{3, 0, 1, 3, 0};
      rst = 1'b1; tick;
      rst = 1'b0; b.EN = 1'b1; tick;
      chk("b_start_dith", 32'(b.dithEN), 32'h8);
      chk("b_start_act", 32'(b.active_ch), 32'd3);
      chk("b_start_hop", 32'(b.ho_pulse), 32'd1);
      for (int k = 0; k < 4; k++) begin
         cur = order[k];
         nx  = order[k + 1];
         oh  = 4'b0001 << nx;
         b.trig = 4'b0001 << cur; tick; b.trig = '0;
         chk($sformatf("b%0d_gap_dith", k), 32'(b.dithEN), 32'h0);
         chk($sformatf("b%0d_gap_act", k), 32'(b.active_ch), 32'(nx));
         tick;
         chk($sformatf("b%0d_ho_dith", k), 32'(b.dithEN), 32'h0);
         b.trig = 4'b0001 << cur; tick; b.trig = '0;
         chk($sformatf("b%0d_run_dith", k), 32'(b.dithEN), 32'(oh));
         chk($sformatf("b%0d_run_hop", k), 32'(b.ho_pulse), 32'd1);
         chk($sformatf("b%0d_run_hot", k), 32'(b.ho_timeout), 32'd0);
         tick;
         chk($sformatf("b%0d_hold_hop", k), 32'(b.ho_pulse), 32'd0);
         chk($sformatf("b%0d_hold_dith", k), 32'(b.dithEN), 32'(oh));
      end

      // Handoff timeout: trig[prev] never arrives; next channel must start 50 cycles in.
      b.trig = 4'b0001; tick; b.trig = '0;
      tick;
      n = 0;
      while (b.dithEN == '0 && n < 200) begin
         tick;
         n++;
      end
      chk("to_cycles", 32'(n), 32'd50);
      chk("to_dith", 32'(b.dithEN), 32'h2);
      chk("to_act", 32'(b.active_ch), 32'd1);
      chk("to_hot", 32'(b.ho_timeout), 32'd1);
      chk("to_hop", 32'(b.ho_pulse), 32'd1);
      tick;
      chk("to_hot_clear", 32'(b.ho_timeout), 32'd0);
      chk("to_hop_clear", 32'(b.ho_pulse), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
